seg7_scan_595: RTL and testbench

- Parametrised multiplexed 7-segment scanner that drives daisy-chained 74HC595 shift registers over a 3-wire serial link (DATA/SCK/RCK).
- Generalises the fixed 8-digit driver: configurable digit count, SCK divider, per-digit dwell (brightness), output polarity, decimal points, blanking and leading-zero suppression.
- Display data is snapshotted once per scan so a full scan never mixes two input values.
- Sits between CPU-visible display registers and the board's LED module pins.

---
 rtl/seg7_scan_595.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_595.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_595.sv
// seg7_scan_595: multiplexed 7-segment scanner driving a daisy-chained 74HC595 pair over DATA/SCK/RCK
module seg7_scan_595 #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 1,
    parameter int HOLD_CYCLES    = 0,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit DIG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    output logic                    LED_DATA,
    output logic                    LED_SCK,
    output logic                    LED_RCK,
    output logic [3:0]              digit_idx,
    output logic                    scan_done
);
    localparam int W    = 8 + NUM_DIGITS;
    localparam int BW   = $clog2(W);
    localparam int CMAX = CLK_DIV > HOLD_CYCLES ? CLK_DIV : HOLD_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
    localparam logic [127:0]  HEX       = 128'h71795E397C776F7F077D6D664F5B063F;

    typedef enum logic [2:0] {LOAD, SLO, SHI, LATCH, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [W-1:0]            word_q, word_d, new_word;
    logic [3:0]              idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d, src_data, data_sh;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d, src_dp, dp_sh;
    logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d, src_blank, blank_sh, sel;
    logic                    snap_lz_q, snap_lz_d, src_lz;
    logic                    data_q, data_d, sck_q, sck_d, rck_q, rck_d, done_q, done_d;
    logic                    first, upper_zero, dark, advance;
    logic [127:0]            hex_sh;
    logic [7:0]              seg;

    always_comb begin
        first     = state_q == LOAD && idx_q == 4'd0;
        src_data  = first ? data : snap_data_q;
        src_dp    = first ? dp : snap_dp_q;
        src_blank = first ? blank : snap_blank_q;
        src_lz    = first ? lz_suppress : snap_lz_q;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (4'(i) >= idx_q && src_data[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        data_sh  = src_data >> {idx_q, 2'b00};
        dp_sh    = src_dp >> idx_q;
        blank_sh = src_blank >> idx_q;
        hex_sh   = HEX >> {data_sh[3:0], 3'b000};
        dark     = blank_sh[0] || (src_lz && upper_zero && idx_q != 4'd0);
        seg      = dark ? 8'h00 : {dp_sh[0], hex_sh[6:0]};
        sel      = dark ? '0 : NUM_DIGITS'(1) << (NUM_DIGITS - 1 - int'(idx_q));
        new_word = {sel ^ {NUM_DIGITS{DIG_ACTIVE_LOW}}, seg ^ {8{SEG_ACTIVE_LOW}}};
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        word_d       = word_q;
        idx_d        = idx_q;
        advance      = 1'b0;
        snap_data_d  = first ? data : snap_data_q;
        snap_dp_d    = first ? dp : snap_dp_q;
        snap_blank_d = first ? blank : snap_blank_q;
        snap_lz_d    = first ? lz_suppress : snap_lz_q;
        case (state_q)
            LOAD: begin
                word_d  = new_word;
                bit_d   = BW'(W - 1);
                cnt_d   = DIV_LAST;
                state_d = SLO;
            end
            SLO: begin
                cnt_d   = cnt_q == '0 ? DIV_LAST : cnt_q - 1'b1;
                state_d = cnt_q == '0 ? SHI : SLO;
            end
            SHI: begin
                cnt_d   = cnt_q == '0 ? DIV_LAST : cnt_q - 1'b1;
                state_d = cnt_q != '0 ? SHI : bit_q == '0 ? LATCH : SLO;
                bit_d   = cnt_q == '0 && bit_q != '0 ? bit_q - 1'b1 : bit_q;
            end
            LATCH: begin
                cnt_d   = cnt_q == '0 ? HOLD_LAST : cnt_q - 1'b1;
                state_d = cnt_q != '0 ? LATCH : HOLD_CYCLES == 0 ? LOAD : HOLD;
                advance = cnt_q == '0 && HOLD_CYCLES == 0;
            end
            default: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? LOAD : HOLD;
                advance = cnt_q == '0;
            end
        endcase
        done_d = advance && idx_q == 4'(NUM_DIGITS - 1);
        idx_d  = advance ? (done_d ? 4'd0 : idx_q + 4'd1) : idx_q;
        sck_d  = state_d == SHI;
        rck_d  = state_d == LATCH;
        data_d = state_d == SLO && state_q != SLO ? word_d[bit_d] : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            bit_q        <= BW'(W - 1);
            word_q       <= '0;
            idx_q        <= '0;
            snap_data_q  <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
            snap_lz_q    <= 1'b0;
            data_q       <= 1'b0;
            sck_q        <= 1'b0;
            rck_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            snap_data_q  <= snap_data_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            snap_lz_q    <= snap_lz_d;
            data_q       <= data_d;
            sck_q        <= sck_d;
            rck_q        <= rck_d;
            done_q       <= done_d;
        end
    end

    assign LED_DATA  = data_q;
    assign LED_SCK   = sck_q;
    assign LED_RCK   = rck_q;
    assign digit_idx = idx_q;
    assign scan_done = done_q;
endmodule

// File: tb/tb_seg7_scan_595.sv
// tb_seg7_scan_595: directed checks of the 595 scanner in a fast and a slow/dimmed configuration
module tb_seg7_scan_595;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = 16'h1234;
    logic [3:0]  dp = 4'd0, blank = 4'd0;
    logic        lz = 1'b0;
    logic        a_data, a_sck, a_rck, a_done, b_data, b_sck, b_rck, b_done;
    logic [3:0]  a_idx, b_idx;
    int          cyc, n_assert, n_fail;
    logic [11:0] a_words[$], b_words[$];
    int          a_rck_cyc[$], a_done_cyc[$];
    logic [11:0] a_sh, b_sh;
    logic        a_sck_p, a_rck_p, b_sck_p, b_rck_p;

    seg7_scan_595 #(.NUM_DIGITS(4), .CLK_DIV(1), .HOLD_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .lz_suppress(lz),
        .LED_DATA(a_data), .LED_SCK(a_sck), .LED_RCK(a_rck), .digit_idx(a_idx), .scan_done(a_done));

    seg7_scan_595 #(.NUM_DIGITS(4), .CLK_DIV(3), .HOLD_CYCLES(5)) dut_b (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .lz_suppress(lz),
        .LED_DATA(b_data), .LED_SCK(b_sck), .LED_RCK(b_rck), .digit_idx(b_idx), .scan_done(b_done));

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Model of the 595 chain: shift on SCK rise, latch word on RCK rise
    always @(negedge clk) begin
        if (rst) begin
            a_sh = '0;
            b_sh = '0;
        end else begin
            if (a_sck && !a_sck_p) a_sh = {a_sh[10:0], a_data};
            if (b_sck && !b_sck_p) b_sh = {b_sh[10:0], b_data};
            if (a_rck && !a_rck_p) begin
                a_words.push_back(a_sh);
                a_rck_cyc.push_back(cyc);
            end
            if (b_rck && !b_rck_p) b_words.push_back(b_sh);
            if (a_done) a_done_cyc.push_back(cyc);
        end
        a_sck_p = a_sck;
        a_rck_p = a_rck;
        b_sck_p = b_sck;
        b_rck_p = b_rck;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic release_rst();
        rst = 1'b0;
        a_words.delete();
        b_words.delete();
        a_rck_cyc.delete();
        a_done_cyc.delete();
    endtask

    task automatic do_reset(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic l);
        rst   = 1'b1;
        data  = d;
        dp    = p;
        blank = b;
        lz    = l;
        repeat (2) tick();
        release_rst();
    endtask

    task automatic wait_a(input int n);
        int g = 0;
        while (a_words.size() < n && g < 2000) begin
            tick();
            g++;
        end
        chk("a_words_timeout", 32'(a_words.size() >= n), 1);
    endtask

    task automatic chk_scan(input string tag, input logic [11:0] w0, input logic [11:0] w1,
                            input logic [11:0] w2, input logic [11:0] w3);
        wait_a(4);
        chk({tag, "_d0"}, a_words[0], w0);
        chk({tag, "_d1"}, a_words[1], w1);
        chk({tag, "_d2"}, a_words[2], w2);
        chk({tag, "_d3"}, a_words[3], w3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        repeat (3) tick();
        chk("rst_data", a_data, 0);
        chk("rst_sck", a_sck, 0);
        chk("rst_rck", a_rck, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_done", a_done, 0);
        chk("rst_b_rck", b_rck, 0);

        release_rst();
        for (int k = 1; k <= 26; k++) begin
            tick();
            chk($sformatf("a_rck_c%0d", k), a_rck, 32'(k == 25));
            if (k == 1) chk("a_first_bit", a_data, 1);
            if (k == 1) chk("a_sck_lo", a_sck, 0);
            if (k == 2) chk("a_sck_hi", a_sck, 1);
            if (k == 26) chk("a_idx_next", a_idx, 1);
        end
        chk("a_first_word", a_words[0], 12'h899);
        chk("a_first_rck_cyc", a_rck_cyc[0], 25);
        chk_scan("scan1234", 12'h899, 12'h4B0, 12'h2A4, 12'h1F9);
        while (cyc < 215) tick();
        chk("done_count", a_done_cyc.size(), 2);
        chk("done_first", a_done_cyc[0], 104);
        chk("done_second", a_done_cyc[1], 208);

        do_reset(16'h1234, 4'd0, 4'd0, 1'b0);
        begin
            int g = 0;
            while (a_words.size() < 2 && g < 500) begin
                tick();
                g++;
            end
        end
        repeat (5) tick();
        chk("mid_idx", a_idx, 2);
        data = 16'h5678;
        wait_a(8);
        chk("mid_d0", a_words[0], 12'h899);
        chk("mid_d1", a_words[1], 12'h4B0);
        chk("mid_d2_old", a_words[2], 12'h2A4);
        chk("mid_d3_old", a_words[3], 12'h1F9);
        chk("mid_d0_new", a_words[4], 12'h880);
        chk("mid_d1_new", a_words[5], 12'h4F8);
        chk("mid_d2_new", a_words[6], 12'h282);
        chk("mid_d3_new", a_words[7], 12'h192);

        do_reset(16'h0030, 4'b0000, 4'b0000, 1'b1);
        chk_scan("lz0030", 12'h8C0, 12'h4B0, 12'h0FF, 12'h0FF);
        do_reset(16'h0030, 4'b0011, 4'b0000, 1'b1);
        chk_scan("lz_dp", 12'h840, 12'h430, 12'h0FF, 12'h0FF);
        do_reset(16'h0000, 4'b0000, 4'b0000, 1'b1);
        chk_scan("lz0000", 12'h8C0, 12'h0FF, 12'h0FF, 12'h0FF);
        do_reset(16'h1034, 4'b0000, 4'b0000, 1'b1);
        chk_scan("lz_inner0", 12'h899, 12'h4B0, 12'h2C0, 12'h1F9);
        do_reset(16'h1234, 4'b0001, 4'b0101, 1'b0);
        chk_scan("blank", 12'h0FF, 12'h4B0, 12'h0FF, 12'h1F9);

        do_reset(16'h1234, 4'd0, 4'd0, 1'b0);
        repeat (10) tick();
        chk("abort_pre_sck", a_sck, 1);
        chk("abort_pre_data", a_data, 1);
        rst = 1'b1;
        tick();
        chk("abort_data", a_data, 0);
        chk("abort_sck", a_sck, 0);
        chk("abort_rck", a_rck, 0);
        chk("abort_idx", a_idx, 0);
        chk("abort_no_latch", a_words.size(), 0);
        release_rst();
        wait_a(1);
        chk("restart_word", a_words[0], 12'h899);
        chk("restart_rck_cyc", a_rck_cyc[0], 25);

        do_reset(16'h1234, 4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 170; k++) begin
            int p;
            tick();
            p = k % 81;
            chk($sformatf("b_sck_c%0d", k), b_sck, 32'(p >= 1 && p <= 72 && ((p - 1) / 3) % 2 == 1));
            chk($sformatf("b_rck_c%0d", k), b_rck, 32'(p >= 73 && p <= 75));
            if (k == 80) chk("b_idx_hold", b_idx, 0);
            if (k == 81) chk("b_idx_next", b_idx, 1);
        end
        chk("b_word0", b_words[0], 12'h899);
        chk("b_word1", b_words[1], 12'h4B0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
